// File: rtl/pzbcm_packet_xbar_switch.sv
// SLAVES x MASTERS packet crossbar: packet-atomic round-robin per output, decode-error drop.
// Define PZBCM_XBAR_OUTPUT_REG_EN to add one register stage per output (latency 1).
module pzbcm_packet_xbar_switch #(
    parameter int SLAVES       = 4,
    parameter int MASTERS      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = (MASTERS > 1) ? $clog2(MASTERS) : 1,
    parameter int SOURCE_WIDTH = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [SLAVES-1:0]                i_valid,
    output logic [SLAVES-1:0]                o_ready,
    input  logic [SLAVES*DATA_WIDTH-1:0]     i_data,
    input  logic [SLAVES-1:0]                i_last,
    input  logic [SLAVES*SELECT_WIDTH-1:0]   i_select,
    output logic [MASTERS-1:0]               o_valid,
    input  logic [MASTERS-1:0]               i_ready,
    output logic [MASTERS*DATA_WIDTH-1:0]    o_data,
    output logic [MASTERS-1:0]               o_last,
    output logic [MASTERS*SOURCE_WIDTH-1:0]  o_source,
    output logic [SLAVES-1:0]                o_decode_error
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e                  state_q [MASTERS];
    state_e                  state_d [MASTERS];
    logic [SOURCE_WIDTH-1:0] owner_q [MASTERS];
    logic [SOURCE_WIDTH-1:0] owner_d [MASTERS];
    logic [SOURCE_WIDTH-1:0] ptr_q   [MASTERS];
    logic [SOURCE_WIDTH-1:0] ptr_d   [MASTERS];

    logic [MASTERS-1:0][SLAVES-1:0]       req;
    logic [MASTERS-1:0][SLAVES-1:0]       gnt;
    logic [SLAVES-1:0]                    dec_err;
    logic [MASTERS-1:0]                   g_valid;
    logic [MASTERS-1:0]                   g_last;
    logic [MASTERS-1:0][DATA_WIDTH-1:0]   g_data;
    logic [MASTERS-1:0][SOURCE_WIDTH-1:0] g_src;
    logic [MASTERS-1:0]                   can_acc;
    logic [MASTERS-1:0]                   acc;

`ifdef PZBCM_XBAR_OUTPUT_REG_EN
    logic [MASTERS-1:0]                   valid_q;
    logic [MASTERS-1:0]                   last_q;
    logic [MASTERS-1:0][DATA_WIDTH-1:0]   data_q;
    logic [MASTERS-1:0][SOURCE_WIDTH-1:0] src_q;
`endif

    always_comb begin
        req     = '0;
        dec_err = '0;
        for (int s = 0; s < SLAVES; s++) begin
            dec_err[s] = int'(i_select[s*SELECT_WIDTH +: SELECT_WIDTH]) >= MASTERS;
            for (int m = 0; m < MASTERS; m++) begin
                req[m][s] = i_valid[s]
                    && (int'(i_select[s*SELECT_WIDTH +: SELECT_WIDTH]) == m);
            end
        end
    end

    // A locked output only listens to its owner; otherwise search starts at ptr.
    always_comb begin
        logic found;
        int   idx;
        gnt   = '0;
        g_src = '0;
        found = 1'b0;
        idx   = 0;
        for (int m = 0; m < MASTERS; m++) begin
            found = 1'b0;
            if (state_q[m] == LOCKED) begin
                g_src[m]             = owner_q[m];
                gnt[m][owner_q[m]]   = req[m][owner_q[m]];
            end else begin
                for (int i = 0; i < SLAVES; i++) begin
                    idx = int'(ptr_q[m]) + i;
                    if (idx >= SLAVES) idx = idx - SLAVES;
                    if (!found && req[m][idx]) begin
                        found       = 1'b1;
                        gnt[m][idx] = 1'b1;
                        g_src[m]    = SOURCE_WIDTH'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < MASTERS; m++) begin
            g_valid[m] = |gnt[m];
            g_last[m]  = i_last[g_src[m]];
            g_data[m]  = i_data[int'(g_src[m])*DATA_WIDTH +: DATA_WIDTH];
`ifdef PZBCM_XBAR_OUTPUT_REG_EN
            can_acc[m] = !valid_q[m] || i_ready[m];
`else
            can_acc[m] = i_ready[m];
`endif
            acc[m]     = g_valid[m] && can_acc[m];
        end
    end

    always_comb begin
        logic rdy;
        rdy            = 1'b0;
        o_ready        = '0;
        o_decode_error = '0;
        for (int s = 0; s < SLAVES; s++) begin
            rdy = dec_err[s];
            for (int m = 0; m < MASTERS; m++) begin
                rdy = rdy | (gnt[m][s] & can_acc[m]);
            end
            o_ready[s]        = !i_rst && rdy;
            o_decode_error[s] = !i_rst && i_valid[s] && i_last[s] && dec_err[s];
        end
    end

    always_comb begin
        for (int m = 0; m < MASTERS; m++) begin
            state_d[m] = state_q[m];
            owner_d[m] = owner_q[m];
            ptr_d[m]   = ptr_q[m];
            if (acc[m]) begin
                if (g_last[m]) begin
                    state_d[m] = IDLE;
                    ptr_d[m]   = (int'(g_src[m]) == SLAVES - 1) ? '0 : g_src[m] + 1'b1;
                end else begin
                    state_d[m] = LOCKED;
                    owner_d[m] = g_src[m];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int m = 0; m < MASTERS; m++) begin
                state_q[m] <= IDLE;
                owner_q[m] <= '0;
                ptr_q[m]   <= '0;
            end
        end else begin
            for (int m = 0; m < MASTERS; m++) begin
                state_q[m] <= state_d[m];
                owner_q[m] <= owner_d[m];
                ptr_q[m]   <= ptr_d[m];
            end
        end
    end

`ifdef PZBCM_XBAR_OUTPUT_REG_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
            last_q  <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            for (int m = 0; m < MASTERS; m++) begin
                if (can_acc[m]) begin
                    valid_q[m] <= g_valid[m];
                    last_q[m]  <= g_last[m];
                    data_q[m]  <= g_data[m];
                    src_q[m]   <= g_src[m];
                end
            end
        end
    end

    always_comb begin
        o_valid  = '0;
        o_last   = '0;
        o_data   = '0;
        o_source = '0;
        for (int m = 0; m < MASTERS; m++) begin
            o_valid[m]                                = valid_q[m];
            o_last[m]                                 = last_q[m];
            o_data[m*DATA_WIDTH +: DATA_WIDTH]        = data_q[m];
            o_source[m*SOURCE_WIDTH +: SOURCE_WIDTH]  = src_q[m];
        end
    end
`else
    // Outputs are zeroed while idle or in reset so nothing leaks from ungranted inputs.
    always_comb begin
        logic v;
        v        = 1'b0;
        o_valid  = '0;
        o_last   = '0;
        o_data   = '0;
        o_source = '0;
        for (int m = 0; m < MASTERS; m++) begin
            v          = !i_rst && g_valid[m];
            o_valid[m] = v;
            if (v) begin
                o_last[m]                                = g_last[m];
                o_data[m*DATA_WIDTH +: DATA_WIDTH]       = g_data[m];
                o_source[m*SOURCE_WIDTH +: SOURCE_WIDTH] = g_src[m];
            end
        end
    end
`endif

endmodule

// File: tb/tb_pzbcm_packet_xbar_switch.sv
// Scoreboard bench for pzbcm_packet_xbar_switch (4 slaves x 3 masters).
// Slave drivers replay beat queues; a monitor pops expected beats per master.
module tb_pzbcm_packet_xbar_switch;

    localparam int S  = 4;
    localparam int M  = 3;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [S-1:0]    i_valid;
    logic [S-1:0]    o_ready;
    logic [S*DW-1:0] i_data;
    logic [S-1:0]    i_last;
    logic [S*SW-1:0] i_select;
    logic [M-1:0]    o_valid;
    logic [M-1:0]    i_ready;
    logic [M*DW-1:0] o_data;
    logic [M-1:0]    o_last;
    logic [M*CW-1:0] o_source;
    logic [S-1:0]    o_dec;

    pzbcm_packet_xbar_switch #(
        .SLAVES     (S),
        .MASTERS    (M),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_data         (i_data),
        .i_last         (i_last),
        .i_select       (i_select),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_last         (o_last),
        .o_source       (o_source),
        .o_decode_error (o_dec)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [SW-1:0] sel;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [CW-1:0] src;
    } exp_t;

    beat_t sq [S][$];
    exp_t  eq [M][$];
    logic  rq [M][$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int s, input int sel, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.d   = d;
        b.l   = l;
        b.sel = SW'(sel);
        sq[s].push_back(b);
    endtask

    task automatic push_exp(input int m, input logic [DW-1:0] d, input logic l, input int src);
        exp_t e;
        e.d   = d;
        e.l   = l;
        e.src = CW'(src);
        eq[m].push_back(e);
    endtask

    function automatic bit all_empty();
        bit r;
        r = 1'b1;
        for (int s = 0; s < S; s++) if (sq[s].size() != 0) r = 1'b0;
        for (int m = 0; m < M; m++) if (eq[m].size() != 0 || rq[m].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (!all_empty() && c < 300) begin
            @(posedge clk);
            c++;
        end
        check({name, "_drain"}, {63'd0, all_empty()}, 64'd1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Slave drivers: present queue heads, pop what the DUT accepted.
    initial begin
        logic [S-1:0] acc;
        i_valid  = '0;
        i_data   = '0;
        i_last   = '0;
        i_select = '0;
        i_ready  = '1;
        forever begin
            @(negedge clk);
            acc = i_valid & o_ready;
            @(posedge clk);
            #1;
            for (int s = 0; s < S; s++) begin
                if (acc[s] && sq[s].size() != 0) void'(sq[s].pop_front());
                i_valid[s]            = sq[s].size() != 0;
                i_data[s*DW +: DW]    = (sq[s].size() != 0) ? sq[s][0].d : '0;
                i_last[s]             = (sq[s].size() != 0) ? sq[s][0].l : 1'b0;
                i_select[s*SW +: SW]  = (sq[s].size() != 0) ? sq[s][0].sel : '0;
            end
            for (int m = 0; m < M; m++) begin
                i_ready[m] = (rq[m].size() != 0) ? rq[m].pop_front() : 1'b1;
            end
        end
    end

    // Monitor: compare every delivered beat and check stall stability.
    initial begin
        logic [M-1:0]  hold_v;
        logic [DW-1:0] hold_d [M];
        exp_t          e;
        hold_v = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = '0;
            end else begin
                for (int m = 0; m < M; m++) begin
                    if (hold_v[m]) begin
                        check($sformatf("m%0d_hold_valid", m), {63'd0, o_valid[m]}, 64'd1);
                        check($sformatf("m%0d_hold_data", m), {32'd0, o_data[m*DW +: DW]},
                              {32'd0, hold_d[m]});
                    end
                    if (o_valid[m] && i_ready[m]) begin
                        if (eq[m].size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL m%0d_unexpected: got data %0h expected none",
                                     m, o_data[m*DW +: DW]);
                        end else begin
                            e = eq[m].pop_front();
                            check($sformatf("m%0d_data", m), {32'd0, o_data[m*DW +: DW]},
                                  {32'd0, e.d});
                            check($sformatf("m%0d_last", m), {63'd0, o_last[m]}, {63'd0, e.l});
                            check($sformatf("m%0d_source", m), {62'd0, o_source[m*CW +: CW]},
                                  {62'd0, e.src});
                        end
                    end
                    hold_v[m] = o_valid[m] && !i_ready[m];
                    hold_d[m] = o_data[m*DW +: DW];
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {61'd0, o_valid}, 64'd0);
        check("rst_ready", {60'd0, o_ready}, 64'd0);
        check("rst_decerr", {60'd0, o_dec}, 64'd0);
        check("rst_data", {32'd0, o_data[DW-1:0]}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // 1) 3-beat packet slave0 -> master2
        for (int i = 0; i < 3; i++) begin
            push_beat(0, 2, 32'hA0 + i, i == 2);
            push_exp(2, 32'hA0 + i, i == 2, 0);
        end
        @(posedge clk);
        #2;
        @(negedge clk);
`ifdef PZBCM_XBAR_OUTPUT_REG_EN
        check("t1_latency", {63'd0, o_valid[2]}, 64'd0);
`else
        check("t1_latency", {63'd0, o_valid[2]}, 64'd1);
`endif
        check("t1_ready", {63'd0, o_ready[0]}, 64'd1);
        wait_drain("t1");

        // 2) slaves 0,1,3 single-beat packets to master1, round robin
        for (int k = 0; k < 2; k++) begin
            push_beat(0, 1, 32'hB0 + k, 1'b1);
            push_beat(1, 1, 32'hC0 + k, 1'b1);
            push_beat(3, 1, 32'hD0 + k, 1'b1);
            push_exp(1, 32'hB0 + k, 1'b1, 0);
            push_exp(1, 32'hC0 + k, 1'b1, 1);
            push_exp(1, 32'hD0 + k, 1'b1, 3);
        end
        @(posedge clk);
        #2;
`ifdef PZBCM_XBAR_OUTPUT_REG_EN
        @(posedge clk);
        #2;
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t2_no_bubble%0d", i), {63'd0, o_valid[1]}, 64'd1);
        end
        wait_drain("t2");

        // 3) slave1 4-beat packet holds master0 against slave2
        for (int i = 0; i < 4; i++) begin
            push_beat(1, 0, 32'hE0 + i, i == 3);
            push_exp(0, 32'hE0 + i, i == 3, 1);
        end
        push_exp(0, 32'hF0, 1'b1, 2);
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        push_beat(2, 0, 32'hF0, 1'b1);
        @(posedge clk);
        #2;
        @(negedge clk);
        check("t3_s2_blocked", {63'd0, o_ready[2]}, 64'd0);
        check("t3_s2_valid", {63'd0, i_valid[2]}, 64'd1);
        check("t3_s1_ready", {63'd0, o_ready[1]}, 64'd1);
        wait_drain("t3");

        // 4) decode error: select 3 with only 3 masters
        push_beat(3, 3, 32'h11, 1'b0);
        push_beat(3, 3, 32'h12, 1'b1);
        @(posedge clk);
        #2;
        @(negedge clk);
        check("t4_b1_ready", {63'd0, o_ready[3]}, 64'd1);
        check("t4_b1_decerr", {63'd0, o_dec[3]}, 64'd0);
        check("t4_b1_valid", {61'd0, o_valid}, 64'd0);
        @(negedge clk);
        check("t4_b2_ready", {63'd0, o_ready[3]}, 64'd1);
        check("t4_b2_decerr", {63'd0, o_dec[3]}, 64'd1);
        check("t4_b2_valid", {61'd0, o_valid}, 64'd0);
        wait_drain("t4");

        // 5) back-pressure toggling 1010 on master1
        for (int i = 0; i < 4; i++) begin
            push_beat(2, 1, 32'h50 + i, i == 3);
            push_exp(1, 32'h50 + i, i == 3, 2);
        end
        for (int i = 0; i < 10; i++) rq[1].push_back(i % 2 == 0);
        wait_drain("t5");

        // 6) reset during beat 2 of a 4-beat packet
        for (int i = 0; i < 4; i++) push_beat(0, 2, 32'h60 + i, i == 3);
`ifndef PZBCM_XBAR_OUTPUT_REG_EN
        push_exp(2, 32'h60, 1'b0, 0);
`endif
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {61'd0, o_valid}, 64'd0);
        check("t6_rst_ready", {60'd0, o_ready}, 64'd0);
        sq[0].delete();
        i_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        push_beat(1, 2, 32'h70, 1'b1);
        push_exp(2, 32'h70, 1'b1, 1);
        wait_drain("t6");

        for (int m = 0; m < M; m++) begin
            check($sformatf("final_m%0d_empty", m), eq[m].size(), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
